// File: rtl/sys_cmd_pkg.sv
// Shared types for the UART command initiator.
// Command set, frame codes, FSM states and frame sizing helpers.
package sys_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_WR      = 2'd0,
    CMD_RD      = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [7:0] CODE_WR  = 8'hAA;
  localparam logic [7:0] CODE_RD  = 8'hBB;
  localparam logic [7:0] CODE_ALU = 8'hCC;
  localparam logic [7:0] CODE_NOP = 8'hDD;

  function automatic logic [2:0] frame_len(input cmd_e c);
    logic [2:0] n;
    n = 3'd2;
    unique case (c)
      CMD_WR:      n = 3'd3;
      CMD_RD:      n = 3'd2;
      CMD_ALU_OP:  n = 3'd4;
      CMD_ALU_NOP: n = 3'd2;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] rsp_len(input cmd_e c);
    logic [1:0] n;
    n = 2'd0;
    unique case (c)
      CMD_WR:      n = 2'd0;
      CMD_RD:      n = 2'd1;
      CMD_ALU_OP:  n = 2'd2;
      CMD_ALU_NOP: n = 2'd2;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sys_cmd_master.sv
// Host-side UART command initiator: serializes one request into a
// byte frame, then gathers the controller's response bytes.
module sys_cmd_master
  import sys_cmd_pkg::*;
#(
  parameter int RSP_TIMEOUT = 4096
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [3:0]  req_addr,
  input  logic [7:0]  req_data,
  input  logic [7:0]  req_op_a,
  input  logic [7:0]  req_op_b,
  input  logic [3:0]  req_fun,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int CW = (RSP_TIMEOUT > 2) ? $clog2(RSP_TIMEOUT) : 1;
  // Counter value after which the next quiet cycle would reach RSP_TIMEOUT-1
  localparam logic [CW-1:0] T_LAST = CW'(RSP_TIMEOUT - 2);

  state_e         state;
  cmd_e           cmd;
  logic [3:0]     addr;
  logic [3:0]     fun;
  logic [7:0]     data;
  logic [7:0]     op_a;
  logic [7:0]     op_b;
  logic [1:0]     idx;
  logic [1:0]     rcnt;
  logic [CW-1:0]  tcnt;

  function automatic logic [7:0] pick(
    input cmd_e       c,
    input logic [1:0] i,
    input logic [3:0] a,
    input logic [7:0] d,
    input logic [7:0] x,
    input logic [7:0] y,
    input logic [3:0] f
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (c)
      CMD_WR:
        if (i == 2'd0)      b = CODE_WR;
        else if (i == 2'd1) b = {4'h0, a};
        else                b = d;
      CMD_RD:
        b = (i == 2'd0) ? CODE_RD : {4'h0, a};
      CMD_ALU_OP:
        if (i == 2'd0)      b = CODE_ALU;
        else if (i == 2'd1) b = x;
        else if (i == 2'd2) b = y;
        else                b = {4'h0, f};
      CMD_ALU_NOP:
        b = (i == 2'd0) ? CODE_NOP : {4'h0, f};
    endcase
    return b;
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= ST_IDLE;
      cmd         <= CMD_WR;
      addr        <= 4'h0;
      fun         <= 4'h0;
      data        <= 8'h00;
      op_a        <= 8'h00;
      op_b        <= 8'h00;
      idx         <= 2'd0;
      rcnt        <= 2'd0;
      tcnt        <= '0;
      req_ready   <= 1'b1;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      rsp_valid   <= 1'b0;
      rsp_data    <= 16'h0000;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state       <= ST_SEND;
            cmd         <= cmd_e'(req_cmd);
            addr        <= req_addr;
            fun         <= req_fun;
            data        <= req_data;
            op_a        <= req_op_a;
            op_b        <= req_op_b;
            idx         <= 2'd0;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            tx_valid    <= 1'b1;
            tx_data     <= pick(cmd_e'(req_cmd), 2'd0, req_addr,
                                req_data, req_op_a, req_op_b, req_fun);
            rsp_data    <= 16'h0000;
            rsp_timeout <= 1'b0;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            if ({1'b0, idx} == frame_len(cmd) - 3'd1) begin
              tx_valid <= 1'b0;
              rcnt     <= 2'd0;
              tcnt     <= '0;
              if (rsp_len(cmd) == 2'd0) begin
                state     <= ST_DONE;
                rsp_valid <= 1'b1;
              end else begin
                state <= ST_WAIT;
              end
            end else begin
              idx     <= idx + 2'd1;
              tx_data <= pick(cmd, idx + 2'd1, addr,
                              data, op_a, op_b, fun);
            end
          end
        end
        ST_WAIT: begin
          if (rx_valid) begin
            if (rcnt[0]) rsp_data[15:8] <= rx_data;
            else         rsp_data[7:0]  <= rx_data;
            rcnt <= rcnt + 2'd1;
            tcnt <= '0;
            if (rcnt == rsp_len(cmd) - 2'd1) begin
              state     <= ST_DONE;
              rsp_valid <= 1'b1;
            end
          end else if (tcnt == T_LAST) begin
            state       <= ST_DONE;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_cmd_master.sv
// Directed bench for sys_cmd_master with tx/rsp scoreboard queues.
// Short response timeout so the abort path is reachable quickly.
module tb_sys_cmd_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cmd;
  logic [3:0]  req_addr;
  logic [7:0]  req_data;
  logic [7:0]  req_op_a;
  logic [7:0]  req_op_b;
  logic [3:0]  req_fun;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_timeout;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  txq[$];
  logic [16:0] rspq[$];

  sys_cmd_master #(.RSP_TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr),
    .req_data(req_data), .req_op_a(req_op_a),
    .req_op_b(req_op_b), .req_fun(req_fun),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic void push_frame(
    input logic [1:0] c, input logic [3:0] a,
    input logic [7:0] d, input logic [7:0] x,
    input logic [7:0] y, input logic [3:0] f,
    input int keep);
    logic [7:0] fr[$];
    case (c)
      2'd0:    fr = '{8'hAA, {4'h0, a}, d};
      2'd1:    fr = '{8'hBB, {4'h0, a}};
      2'd2:    fr = '{8'hCC, x, y, {4'h0, f}};
      default: fr = '{8'hDD, {4'h0, f}};
    endcase
    for (int i = 0; i < fr.size() && i < keep; i++)
      txq.push_back(fr[i]);
  endfunction

  task automatic issue(
    input logic [1:0] c, input logic [3:0] a,
    input logic [7:0] d, input logic [7:0] x,
    input logic [7:0] y, input logic [3:0] f,
    input int keep);
    check("req_ready_idle", req_ready, 1);
    push_frame(c, a, d, x, y, f, keep);
    req_valid = 1'b1;
    req_cmd   = c;
    req_addr  = a;
    req_data  = d;
    req_op_a  = x;
    req_op_b  = y;
    req_fun   = f;
    tick();
    req_valid = 1'b0;
    check("tx_valid_after_accept", tx_valid, 1);
    check("busy_after_accept", busy, 1);
  endtask

  // Scoreboard monitor plus stall-stability watch, sampled mid-cycle
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (prev_stall) begin
        check("stall_valid_held", tx_valid, 1);
        check("stall_data_held", tx_data, prev_byte);
      end
      if (tx_valid && tx_ready) begin
        if (txq.size() == 0)
          check("tx_extra_byte", 1, 0);
        else
          check("tx_byte", tx_data, txq.pop_front());
      end
      if (rsp_valid) begin
        if (rspq.size() == 0)
          check("rsp_extra", 1, 0);
        else
          check("rsp", {rsp_timeout, rsp_data}, rspq.pop_front());
      end
      prev_stall = tx_valid && !tx_ready;
      prev_byte  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int n;
    RST = 1'b0; req_valid = 1'b0; req_cmd = 2'd0;
    req_addr = 4'h0; req_data = 8'h00; req_op_a = 8'h00;
    req_op_b = 8'h00; req_fun = 4'h0; tx_ready = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 16'h0000);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_busy", busy, 0);
    RST = 1'b1;
    tick();

    // WR, back-to-back bytes, completion right after last handshake
    tx_ready = 1'b1;
    rspq.push_back({1'b0, 16'h0000});
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 99);
    check("wr_b0", tx_data, 8'hAA);
    tick();
    check("wr_b1", tx_data, 8'h05);
    tick();
    check("wr_b2", tx_data, 8'h3C);
    tick();
    check("wr_tx_drop", tx_valid, 0);
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_data", rsp_data, 16'h0000);
    check("wr_not_ready_done", req_ready, 0);
    tick();
    check("wr_rsp_pulse", rsp_valid, 0);
    check("wr_ready_back", req_ready, 1);

    // RD with a single reply byte
    rspq.push_back({1'b0, 16'h0081});
    issue(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 99);
    check("rd_b0", tx_data, 8'hBB);
    tick();
    check("rd_b1", tx_data, 8'h02);
    tick();
    check("rd_wait_tx", tx_valid, 0);
    rx_data = 8'h81; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_data", rsp_data, 16'h0081);
    check("rd_rsp_timeout", rsp_timeout, 0);
    check("rd_ready_low", req_ready, 0);
    tick();
    check("rd_ready_back", req_ready, 1);

    // ALU_OP with alternating tx_ready stalls
    tx_ready = 1'b0;
    rspq.push_back({1'b0, 16'h0200});
    issue(2'd2, 4'h0, 8'h00, 8'h10, 8'h20, 4'h2, 99);
    check("alu_b0", tx_data, 8'hCC);
    n = 0;
    while (tx_valid && n < 20) begin
      tick();
      tx_ready = !tx_ready;
      n++;
    end
    check("alu_send_done", tx_valid, 0);
    rx_data = 8'h00; rx_valid = 1'b1;
    tick();
    check("alu_mid_no_rsp", rsp_valid, 0);
    rx_data = 8'h02;
    tick();
    rx_valid = 1'b0;
    check("alu_rsp_valid", rsp_valid, 1);
    check("alu_rsp_data", rsp_data, 16'h0200);
    tick();

    // ALU_NOP: one reply then silence -> timeout abort
    tx_ready = 1'b1;
    rspq.push_back({1'b1, 16'h0055});
    issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 99);
    tick();
    tick();
    rx_data = 8'h55; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (6) tick();
    check("to_not_yet", rsp_valid, 0);
    tick();
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_timeout", rsp_timeout, 1);
    check("to_rsp_data", rsp_data, 16'h0055);
    tick();
    check("to_timeout_held", rsp_timeout, 1);
    check("to_ready_back", req_ready, 1);

    // RD with spurious rx during SEND and on the last handshake
    rspq.push_back({1'b0, 16'h0007});
    issue(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 99);
    check("sp_timeout_cleared", rsp_timeout, 0);
    check("sp_data_cleared", rsp_data, 16'h0000);
    rx_data = 8'hFF; rx_valid = 1'b1;
    tick();
    tick();
    rx_valid = 1'b0;
    check("sp_no_rsp", rsp_valid, 0);
    check("sp_busy", busy, 1);
    rx_data = 8'h07; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("sp_rsp_valid", rsp_valid, 1);
    check("sp_rsp_data", rsp_data, 16'h0007);
    tick();

    // Reset in the middle of an ALU_OP frame
    issue(2'd2, 4'h0, 8'h00, 8'h11, 8'h22, 4'h3, 2);
    tick();
    tick();
    RST = 1'b0;
    tick();
    check("mr_tx_valid", tx_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_req_ready", req_ready, 1);
    check("mr_rsp_valid", rsp_valid, 0);
    RST = 1'b1;
    tick();
    check("mr_idle_no_rsp", rsp_valid, 0);
    rspq.push_back({1'b0, 16'h0000});
    issue(2'd0, 4'hA, 8'h5A, 8'h00, 8'h00, 4'h0, 99);
    check("mr_wr_b0", tx_data, 8'hAA);
    repeat (3) tick();
    check("mr_wr_rsp", rsp_valid, 1);
    repeat (3) tick();

    check("txq_drained", txq.size(), 0);
    check("rspq_drained", rspq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_cmd_master.md
# sys_cmd_master

Host-side command initiator for the system's UART command protocol. Accepts one high-level request (register write, register read, ALU operation with operands, ALU operation without operands) and serializes it into the command byte frame. It then collects the response bytes returned by the system controller. Sits between a test or host agent and a byte-level UART transmitter/receiver pair, forming the far end of the link from the system controller.

## Interface
- `RSP_TIMEOUT`, default 4096: idle cycles allowed between response bytes before the request is aborted; minimum 2.
- `CLK` input 1: single clock.
- `RST` input 1: synchronous, active-low reset.
- `req_valid` input 1: request offered.
- `req_ready` output 1: high only in IDLE.
- `req_cmd` input 2: 0=WR, 1=RD, 2=ALU_OP, 3=ALU_NOP.
- `req_addr` input 4: register address (WR/RD).
- `req_data` input 8: write data (WR).
- `req_op_a` input 8: operand A (ALU_OP).
- `req_op_b` input 8: operand B (ALU_OP).
- `req_fun` input 4: ALU function (ALU_OP/ALU_NOP).
- `tx_data` output 8: byte to UART TX.
- `tx_valid` output 1: byte offered.
- `tx_ready` input 1: byte accepted this cycle.
- `rx_data` input 8: byte from UART RX.
- `rx_valid` input 1: one-cycle strobe per received byte.
- `rsp_valid` output 1: one-cycle completion pulse.
- `rsp_data` output 16: response; RD = {8'h00, byte}; ALU = {byte1, byte0}; WR = 16'h0000.
- `rsp_timeout` output 1: qualifies `rsp_valid` when the request was aborted.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Request fields are captured on `req_valid && req_ready`.
- Frames, in transmit order:
  - WR: 8'hAA, {4'h0,addr}, data.
  - RD: 8'hBB, {4'h0,addr}.
  - ALU_OP: 8'hCC, A, B, {4'h0,fun}.
  - ALU_NOP: 8'hDD, {4'h0,fun}.
- Expected response bytes: WR 0, RD 1, ALU_OP/ALU_NOP 2 (LSB first).
- States and transitions:
  - IDLE → SEND on accept.
  - SEND → WAIT_RSP after the last byte handshake; goes to DONE instead if the expected count is 0.
  - WAIT_RSP → DONE on the final expected byte, or on timeout.
  - DONE → IDLE unconditionally.
- Byte index counts 0..len-1. Response counter counts 0..expected-1.
- Timeout counter:
  - Cleared on entry to WAIT_RSP and on every `rx_valid`.
  - Increments each WAIT_RSP cycle without `rx_valid`.
  - On reaching RSP_TIMEOUT-1 the FSM goes to DONE with `rsp_timeout`=1.
  - `rsp_data` then holds whatever bytes arrived; missing bytes read 0.
- `rx_valid` outside WAIT_RSP is ignored. This includes the cycle of the last tx handshake.
- Reset at any point: immediate return to IDLE; the partial frame is abandoned and no `rsp_valid` is issued.
- Reset values: `req_ready`=1, `tx_valid`=0, `tx_data`=8'h00, `rsp_valid`=0, `rsp_data`=16'h0000, `rsp_timeout`=0, `busy`=0.

## Timing
- Cycle after accept: `tx_valid`=1 with the first frame byte.
- While `tx_valid && !tx_ready`, `tx_data` is held stable.
- After a handshake, the next byte is presented in the following cycle. A continuously high `tx_ready` therefore yields one byte per cycle.
- `tx_valid` drops the cycle after the last handshake.
- Response latency: `rsp_valid` is high the cycle after the final `rx_valid` (DONE state). `req_ready` rises the cycle after that.
- WR: `rsp_valid` is high the cycle after the last tx handshake.
- `rsp_data` and `rsp_timeout` remain stable until the next accept. `rsp_timeout` is cleared on accept.
- Minimum request-to-request spacing: frame length + response bytes + 2 cycles.

## Structure
- Shared package `sys_cmd_pkg` holds:
  - Command enum (WR/RD/ALU_OP/ALU_NOP).
  - Frame codes 8'hAA/8'hBB/8'hCC/8'hDD.
  - FSM state enum.
  - A function mapping command → frame length and → response byte count.
- Single module, no sub-module; the timeout counter and byte mux are inline.

## Test plan
- WR addr=4'h5 data=8'h3C, `tx_ready`=1 → `tx_data` 8'hAA, 8'h05, 8'h3C on 3 consecutive cycles; `rsp_valid` next cycle with `rsp_data`=16'h0000.
- RD addr=4'h2, reply 8'h81 → bytes 8'hBB, 8'h02; `rsp_valid` cycle after the `rx_valid`, `rsp_data`=16'h0081, `rsp_timeout`=0.
- ALU_OP A=8'h10 B=8'h20 fun=4'h2, `tx_ready` toggled 1/0, replies 8'h00 then 8'h02 → 8'hCC, 8'h10, 8'h20, 8'h02 held stable across stalls; `rsp_data`=16'h0200.
- ALU_NOP fun=4'h0 with RSP_TIMEOUT=8, one reply 8'h55 then silence → `rsp_valid` with `rsp_timeout`=1, `rsp_data`=16'h0055, 8 cycles after the byte.
- Spurious `rx_valid` (8'hFF) during SEND of an RD, then reply 8'h07 → 8'hFF ignored; `rsp_data`=16'h0007.
- `RST`=0 mid-SEND of an ALU_OP after 2 bytes → next cycle `tx_valid`=0, `busy`=0, `req_ready`=1, no `rsp_valid`; a following WR frame is correct.
